// File: rtl/lsu_ram_master_if.sv
// Request/response handshake and RAM port-A bus between the core memory stage and lsu_ram_master.
// The master modport is the LSU's view; the slave modport is the view of the core and RAM around it.
interface lsu_ram_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  ram_en_o;
    logic [3:0]            ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/lsu_ram_master.sv
// Load/store master for block-RAM port A: lane enables, replicated store data,
// one-cycle read latency absorption, load alignment/extension and error responses.
module lsu_ram_master #(
    parameter int DATA_DEPTH = 8192,
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    lsu_ram_master_if.master bus
);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DATA_DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    state_t                state_r;
    logic                  we_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [1:0]            off_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [31:0]           rsp_rdata_r;
    logic                  ram_en_r;
    logic [3:0]            ram_we_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [31:0]           ram_wdata_r;

    logic                  size_err_s;
    logic                  range_err_s;
    logic                  err_s;
    logic [3:0]            mask_s;
    logic [31:0]           wdata_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;
    logic [31:0]           ext_s;

    // Decode the incoming request: legality, lane enables and replicated store data.
    always_comb begin
        size_err_s  = 1'b0;
        mask_s      = 4'b0000;
        wdata_s     = bus.req_wdata_i;
        case (bus.req_size_i)
            2'b00: begin
                mask_s  = 4'b1000 >> bus.req_addr_i[1:0];
                wdata_s = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                size_err_s = bus.req_addr_i[0];
                mask_s     = bus.req_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_s    = {2{bus.req_wdata_i[15:0]}};
            end
            2'b10: begin
                size_err_s = (bus.req_addr_i[1:0] != 2'b00);
                mask_s     = 4'b1111;
            end
            default: begin
                size_err_s = 1'b1;
                mask_s     = 4'b0000;
            end
        endcase
        range_err_s = ({1'b0, bus.req_addr_i} >= ADDR_LIMIT);
        err_s       = size_err_s | range_err_s;
    end

    // Pick the addressed lane(s) from the RAM word and sign- or zero-extend.
    always_comb begin
        byte_s = bus.ram_rdata_i[{off_r, 3'b000} +: 8];
        half_s = off_r[1] ? bus.ram_rdata_i[31:16] : bus.ram_rdata_i[15:0];
        case (size_r)
            2'b00: begin
                if (unsigned_r) begin
                    ext_s = {24'h000000, byte_s};
                end else begin
                    ext_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            2'b01: begin
                if (unsigned_r) begin
                    ext_s = {16'h0000, half_s};
                end else begin
                    ext_s = {{16{half_s[15]}}, half_s};
                end
            end
            default: ext_s = bus.ram_rdata_i;
        endcase
    end

    // Request FSM; every bus output except req_ready is a register updated here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            unsigned_r  <= 1'b0;
            off_r       <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 4'b0000;
            ram_addr_r  <= '0;
            ram_wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (err_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                            state_r     <= RESP;
                        end else begin
                            we_r       <= bus.req_we_i;
                            size_r     <= bus.req_size_i;
                            unsigned_r <= bus.req_unsigned_i;
                            off_r      <= bus.req_addr_i[1:0];
                            ram_en_r   <= 1'b1;
                            ram_we_r   <= bus.req_we_i ? mask_s : 4'b0000;
                            ram_addr_r <= {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            if (bus.req_we_i) begin
                                ram_wdata_r <= wdata_s;
                            end else begin
                                ram_wdata_r <= ram_wdata_r;
                            end
                            state_r    <= ACCESS;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_en_r <= 1'b0;
                    ram_we_r <= 4'b0000;
                    if (we_r) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        state_r     <= RESP;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= ext_s;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    ram_en_r    <= 1'b0;
                    ram_we_r    <= 4'b0000;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state_r == IDLE);
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_err_o   = rsp_err_r;
    assign bus.rsp_rdata_o = rsp_rdata_r;
    assign bus.ram_en_o    = ram_en_r;
    assign bus.ram_we_o    = ram_we_r;
    assign bus.ram_addr_o  = ram_addr_r;
    assign bus.ram_wdata_o = ram_wdata_r;
endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a behavioural port-A RAM and a response scoreboard.
module tb_lsu_ram_master;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   en_count;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    lsu_ram_master_if #(.ADDR_WIDTH(32)) bus ();

    lsu_ram_master #(.DATA_DEPTH(8192), .ADDR_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-lane writes, registered read one cycle after enable.
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            en_count = en_count + 1;
            for (int k = 0; k < 4; k++) begin
                if (bus.ram_we_o[3-k]) mem[bus.ram_addr_o[9:2]][8*k +: 8] <= bus.ram_wdata_o[8*k +: 8];
            end
            bus.ram_rdata_i <= mem[bus.ram_addr_o[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input logic hold);
        int          lat;
        int          en0;
        logic [3:0]  we_seen;
        logic [31:0] addr_seen;
        logic [31:0] wdata_seen;
        exp_t        e;
        logic [31:0] held;
        we_seen = 4'hx; addr_seen = 32'hx; wdata_seen = 32'hx;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.rsp_ready_i    = !hold;
        check({tag, "_req_ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        en0 = en_count;
        @(posedge clk);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        #1 bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 20) begin
            if (bus.ram_en_o) begin
                we_seen = bus.ram_we_o; addr_seen = bus.ram_addr_o; wdata_seen = bus.ram_wdata_o;
            end
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (bus.rsp_valid_o && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, bus.rsp_rdata_o, e.rdata);
            check({tag, "_err"}, {31'd0, bus.rsp_err_o}, {31'd0, e.err});
        end else begin
            sb.delete();
        end
        check({tag, "_en_pulses"}, en_count - en0, exp_err ? 0 : 1);
        if (!exp_err) begin
            check({tag, "_ram_we"}, {28'd0, we_seen}, {28'd0, exp_mask});
            check({tag, "_ram_addr"}, addr_seen, {addr[31:2], 2'b00});
            if (we) check({tag, "_ram_wdata"}, wdata_seen, exp_wdata);
        end
        if (hold) begin
            held = bus.rsp_rdata_o;
            en0  = en_count;
            repeat (3) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
                check({tag, "_hold_rdata"}, bus.rsp_rdata_o, held);
                check({tag, "_hold_ready"}, {31'd0, bus.req_ready_o}, 32'd0);
            end
            check({tag, "_hold_no_ram"}, en_count - en0, 0);
            @(negedge clk);
            bus.rsp_ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_rsp_done"}, {31'd0, bus.rsp_valid_o}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.req_ready_o}, 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0; en_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[8'h40] = 32'h8001_7F00;
        mem[8'h80] = 32'h1122_3344;
        mem[8'hFF] = 32'hCAFE_F00D;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
        bus.rsp_ready_i = 1'b1; bus.ram_rdata_i = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err_o}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_ram_en",    {31'd0, bus.ram_en_o}, 32'd0);
        check("rst_ram_we",    {28'd0, bus.ram_we_o}, 32'd0);
        check("rst_ram_addr",  bus.ram_addr_o, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req("st_b101",  1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 32'h0, 1'b0, 2, 4'b0100, 32'hABAB_ABAB, 1'b0);
        run_req("ld_h102s", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("ld_h102u", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_8001, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("ld_b103u", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("ld_b103s", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("ld_b101s", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFF_FFAB, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("er_h101",  1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 1'b0);
        run_req("er_w102",  1'b1, 2'b10, 1'b0, 32'h102, 32'h5555_5555, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 1'b0);
        run_req("er_w8000", 1'b0, 2'b10, 1'b0, 32'h8000, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 1'b0);
        run_req("er_size3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 1'b0);
        run_req("ld_w7ffc", 1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("st_h106",  1'b1, 2'b01, 1'b0, 32'h106, 32'h1234_BEEF, 32'h0, 1'b0, 2, 4'b0011, 32'hBEEF_BEEF, 1'b0);
        run_req("ld_h106u", 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 32'h0000_BEEF, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("st_h104",  1'b1, 2'b01, 1'b0, 32'h104, 32'h0000_7A5C, 32'h0, 1'b0, 2, 4'b1100, 32'h7A5C_7A5C, 1'b0);
        run_req("ld_w104",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hBEEF_7A5C, 1'b0, 3, 4'b0000, 32'h0, 1'b0);
        run_req("ld_hold",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001_AB00, 1'b0, 3, 4'b0000, 32'h0, 1'b1);

        // Reset while a word store sits in ACCESS: enables must drop without waiting for a clock.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b10;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h200; bus.req_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        check("rst_mid_en_before", {31'd0, bus.ram_en_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_en",  {31'd0, bus.ram_en_o}, 32'd0);
        check("rst_mid_we",  {28'd0, bus.ram_we_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
        check("rst_mid_ready",  {31'd0, bus.req_ready_o}, 32'd1);
        check("rst_mid_mem",    mem[8'h80], 32'h1122_3344);
        run_req("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122_3344, 1'b0, 3, 4'b0000, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
